// File: rtl/bus_slave_responder.sv
// Slave responder: word-addressed register file behind one decoded select.
// Each accepted command completes after WAIT_CYCLES wait states.
module bus_slave_responder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_slave,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wdone,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic op_wr_q;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic accept;
  logic enter_resp;
  logic tgt_wr;
  logic [ADDR_WIDTH-1:0] tgt_addr;
  logic [DATA_WIDTH-1:0] tgt_wdata;

  assign accept = (state_q == S_IDLE) && (wen ^ ren);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wen && ren) begin
          state_d = S_ERR;
        end else if (accept) begin
          cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the response is entered straight from IDLE,
  // so the live command is used instead of the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      tgt_wr    = wen;
      tgt_addr  = address_slave;
      tgt_wdata = wdata;
    end else begin
      tgt_wr    = op_wr_q;
      tgt_addr  = addr_q;
      tgt_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
      rdata    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address_slave;
        wdata_q <= wdata;
        op_wr_q <= wen;
      end
      if (enter_resp && !tgt_wr) begin
        rdata <= mem[tgt_addr];
      end
      if (busy && (wen || ren) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && tgt_wr) begin
      mem[tgt_addr] <= tgt_wdata;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign rvalid = (state_q == S_RESP) && !op_wr_q;
  assign wdone  = (state_q == S_RESP) && op_wr_q;
  assign err    = (state_q == S_ERR);

endmodule

// File: tb/tb_bus_slave_responder.sv
// Bench for bus_slave_responder: directed cases plus randomized traffic
// against a transaction-level memory and drop-count model.
module tb_bus_slave_responder;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] address_slave = '0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       wdone;
  logic       busy;
  logic       err;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [128];
  int exp_drop = 0;

  always #5 clk = ~clk;

  bus_slave_responder #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8),
    .WAIT_CYCLES(W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address_slave(address_slave),
    .wen          (wen),
    .ren          (ren),
    .wdata        (wdata),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .wdone        (wdone),
    .busy         (busy),
    .err          (err),
    .drop_cnt     (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_drop();
    if (exp_drop < 255) exp_drop++;
  endtask

  // Issue one command from IDLE and follow it to completion.
  // noisy: throw random requests at the slave while it is busy.
  task automatic cmd(input bit wr, input logic [6:0] a,
                     input logic [7:0] d, input bit noisy);
    chk("idle_busy", 32'(busy), 32'd0);
    wen = wr;
    ren = !wr;
    address_slave = a;
    wdata = d;
    @(negedge clk);
    for (int k = 1; k <= W + 1; k++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("rvalid", 32'(rvalid), 32'(!wr && k == W + 1));
      chk("wdone", 32'(wdone), 32'(wr && k == W + 1));
      chk("err", 32'(err), 32'd0);
      if (!wr && k == W + 1) chk("rdata", 32'(rdata), 32'(mdl[a]));
      {wen, ren} = noisy ? 2'($urandom_range(0, 3)) : 2'b00;
      address_slave = 7'($urandom);
      wdata = 8'($urandom);
      if (wen || ren) bump_drop();
      @(negedge clk);
    end
    if (wr) mdl[a] = d;
    wen = 1'b0;
    ren = 1'b0;
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int phase;
    int drops;

    // 1: reset
    #50;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_strobes", {29'd0, rvalid, wdone, err}, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_out", {21'd0, rdata, rvalid, wdone, err}, 32'd0);
    end

    // fill storage so every later read has a known model value
    for (int a = 0; a < 128; a++) cmd(1'b1, 7'(a), 8'($urandom), 1'b0);

    // 2: write then read back
    cmd(1'b1, 7'h04, 8'hA5, 1'b0);
    cmd(1'b0, 7'h04, 8'h00, 1'b0);
    chk("t2_rdata_hold", 32'(rdata), 32'hA5);

    // 3: write request held through the busy window
    wen = 1'b1;
    address_slave = 7'h7F;
    wdata = 8'h3C;
    for (int i = 0; i < W + 2; i++) @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < W + 1; i++) bump_drop();
    mdl[7'h7F] = 8'h3C;
    chk("t3_drop", 32'(drop_cnt), 32'(exp_drop));
    chk("t3_busy", 32'(busy), 32'd0);
    cmd(1'b0, 7'h7F, 8'h00, 1'b0);
    chk("t3_rdata", 32'(rdata), 32'h3C);

    // 4: simultaneous read and write
    wen = 1'b1;
    ren = 1'b1;
    address_slave = 7'h10;
    wdata = ~mdl[7'h10];
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_nostrobe", {30'd0, rvalid, wdone}, 32'd0);
    @(negedge clk);
    chk("t4_err_off", 32'(err), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    cmd(1'b0, 7'h10, 8'h00, 1'b0);

    // 5: reset aborts a write in its wait states
    cmd(1'b1, 7'h20, 8'hAA, 1'b0);
    wen = 1'b1;
    address_slave = 7'h20;
    wdata = 8'h55;
    @(negedge clk);
    wen = 1'b0;
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    exp_drop = 0;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_drop_rst", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      chk("t5_no_wdone", 32'(wdone), 32'd0);
      @(negedge clk);
    end
    cmd(1'b0, 7'h20, 8'h00, 1'b0);
    chk("t5_old_data", 32'(rdata), 32'hAA);

    // randomized traffic with interference while busy
    for (int n = 0; n < 80; n++) begin
      cmd(1'($urandom), 7'($urandom), 8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // 6: sustained requests drive drop_cnt to saturation
    rst = 1'b1;
    #1;
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    ren = 1'b1;
    address_slave = 7'h33;
    phase = 0;
    drops = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (phase != 0) drops++;
      phase = (phase + 1) % (W + 2);
      if (i == 99) chk("t6_mid_drop", 32'(drop_cnt),
                       32'((drops > 255) ? 255 : drops));
    end
    ren = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("t6_saturated", 32'(drop_cnt), 32'hFF);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
